alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one `execute` ALU among NUM_REQ requesters, for example the main issue slot and an address/branch helper.
//  Grants at most one request per cycle using round-robin arbitration.
//  Drives the shared ALU combinationally and registers the result with the requester ID.
//  Presents results on a single valid/ready response channel with backpressure.
// PARAMETERS
//  DWIDTH   32  operand and result width
//  NUM_REQ  2   number of requesters; legal range 2..8
//  IDW      $clog2(NUM_REQ)  width of the requester ID (derived localparam)
// PORTS
//  clk           in   1               clock; all state updates on posedge
//  reset         in   1               synchronous, active-high reset
//  req_valid_i   in   NUM_REQ         per-requester request valid
//  req_ready_o   out  NUM_REQ         per-requester accept; one-hot or all-zero
//  req_op_i      in   NUM_REQ x 4     ALU op (ALU_* encodings from constants.svh)
//  req_a_i       in   NUM_REQ x DWIDTH  operand A
//  req_b_i       in   NUM_REQ x DWIDTH  operand B
//  rsp_valid_o   out  1               response register holds a result
//  rsp_ready_i   in   1               consumer accepts the response
//  rsp_id_o      out  IDW             index of the requester that owns the result
//  rsp_result_o  out  DWIDTH          registered ALU result
// BEHAVIOUR
//  - Reset: rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rr_ptr=0.
//    All pending state is discarded, including during a stalled response.
//    req_ready_o is all-zero while reset is asserted.
//  - can_accept = !rsp_valid_o || rsp_ready_i.
//    This is a single-entry output register with same-cycle replace.
//  - Arbitration when can_accept=1:
//    - Search req_valid_i starting at rr_ptr, wrapping modulo NUM_REQ.
//    - The first valid index g is granted: req_ready_o[g]=1 (combinational from valid).
//  - If can_accept=0, or no request is valid: req_ready_o=0 and rr_ptr holds.
//  - A transfer occurs when req_valid_i[g] && req_ready_o[g]. On that posedge:
//    - rsp_result_o <= execute(op[g], a[g], b[g])
//    - rsp_id_o <= g
//    - rsp_valid_o <= 1
//    - rr_ptr <= (g+1) mod NUM_REQ
//  - Pop without push (rsp_valid_o && rsp_ready_i, no transfer): rsp_valid_o <= 0; id and result hold.
//  - Pop and push in the same cycle: the new result replaces the old one and rsp_valid_o stays 1. There is no bubble.
//  - Latency: the result is visible one cycle after the transfer. Throughput is 1 per cycle when rsp_ready_i=1.
//  - Requesters keep valid and payload stable until ready is asserted.
//    A requester may drop valid only after its transfer.
//    Non-granted payloads are ignored.
//  - Response payload is stable while rsp_valid_o && !rsp_ready_i.
//  - Arithmetic is entirely the instantiated ALU's:
//    - shamt_i is tied to req_b_i[g][4:0].
//    - Unknown op codes behave as ALU_ADD.
//  - Starvation: with all requesters continuously valid, each is granted once every NUM_REQ transfers.
// STRUCTURE
//  - Shared package or constants.svh: ALU_* op encodings, reused unchanged.
//    Add typedef alu_req_t {op, a, b} for per-requester payloads.
//  - One sub-module: instance u_execute of `execute` (DWIDTH passed through), fed by the grant mux.
//  - Local logic:
//    - round-robin priority encoder, kept as a function; no separate module
//    - rr_ptr register
//    - response register
// TESTING
//  - Reset: hold reset 2 cycles with req_valid_i=11.
//    -> req_ready_o=00, rsp_valid_o=0, rsp_result_o=0.
//    - After release: req0 granted first (rr_ptr=0).
//  - Single request: req1 sends ALU_SUB, a=5, b=7.
//    -> req_ready_o=10 that cycle.
//    -> Next cycle: rsp_valid_o=1, rsp_id_o=1, rsp_result_o=32'hFFFF_FFFE.
//  - Fairness: both valid continuously, ADD with a=id, b=0, rsp_ready_i=1.
//    -> rsp_id_o sequence 0,1,0,1...
//    -> One result per cycle, no bubbles.
//  - Backpressure:
//    - req0 sends SRA a=32'h8000_0000 b=4, then rsp_ready_i=0 for 3 cycles.
//      -> rsp_result_o=32'hF800_0000 stays stable and req_ready_o=00 throughout.
//    - Pending req1 is granted in the same cycle that rsp_ready_i returns to 1.
//  - Reset mid-operation: assert reset while rsp_valid_o=1 and stalled.
//    -> The next cycle shows rsp_valid_o=0 and rr_ptr=0.
//    -> The stalled result is never delivered.
//  - Op sweep via req1: SLT a=-1 b=1 -> 1; SLTU a=-1 b=1 -> 0; PASS_B b=32'h1234_5000 -> 32'h1234_5000; op=4'hF a=2 b=3 -> 5.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Purpose: shared ALU op encodings and request payload type for the ALU arbiter
//          and its execute unit.
// Ports:   none (package).
package alu_arbiter_pkg;

    localparam int unsigned OPW  = 4;
    localparam int unsigned XLEN = 32;

    // ALU op encodings; any code not listed executes as ALU_ADD
    localparam logic [OPW-1:0] ALU_ADD    = 4'h0;
    localparam logic [OPW-1:0] ALU_SUB    = 4'h1;
    localparam logic [OPW-1:0] ALU_SLL    = 4'h2;
    localparam logic [OPW-1:0] ALU_SLT    = 4'h3;
    localparam logic [OPW-1:0] ALU_SLTU   = 4'h4;
    localparam logic [OPW-1:0] ALU_XOR    = 4'h5;
    localparam logic [OPW-1:0] ALU_SRL    = 4'h6;
    localparam logic [OPW-1:0] ALU_SRA    = 4'h7;
    localparam logic [OPW-1:0] ALU_OR     = 4'h8;
    localparam logic [OPW-1:0] ALU_AND    = 4'h9;
    localparam logic [OPW-1:0] ALU_PASS_B = 4'hA;

    // Per-requester payload at the default datapath width
    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_execute.sv
// Purpose: combinational ALU shared by all requesters of alu_arbiter.
// Ports:   i_op    - ALU op code (ALU_*)
//          i_a     - operand A
//          i_b     - operand B
//          i_shamt - shift amount
//          o_result- combinational result
module execute
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [OPW-1:0]    i_op,
    input  logic [DWIDTH-1:0] i_a,
    input  logic [DWIDTH-1:0] i_b,
    input  logic [4:0]        i_shamt,
    output logic [DWIDTH-1:0] o_result
);

    // Result select; the default arm makes unknown codes behave as ADD
    always_comb begin
        o_result = i_a + i_b;
        case (i_op)
            ALU_SUB:    o_result = i_a - i_b;
            ALU_SLL:    o_result = i_a << i_shamt;
            ALU_SLT:    o_result = {{(DWIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU:   o_result = {{(DWIDTH-1){1'b0}}, (i_a < i_b)};
            ALU_XOR:    o_result = i_a ^ i_b;
            ALU_SRL:    o_result = i_a >> i_shamt;
            ALU_SRA:    o_result = DWIDTH'($signed(i_a) >>> i_shamt);
            ALU_OR:     o_result = i_a | i_b;
            ALU_AND:    o_result = i_a & i_b;
            ALU_PASS_B: o_result = i_b;
            default:    o_result = i_a + i_b;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: round-robin share of one execute ALU among NUM_REQ requesters, with a
//          single-entry registered valid/ready response channel.
// Ports:   clk, reset    - clock, synchronous active-high reset
//          req_valid_i   - per-requester request valid
//          req_ready_o   - per-requester accept (one-hot or zero)
//          req_op_i/a/b  - per-requester ALU op and operands
//          rsp_valid_o   - response register holds a result
//          rsp_ready_i   - consumer accepts the response
//          rsp_id_o      - requester that owns the result
//          rsp_result_o  - registered ALU result
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0][OPW-1:0]     req_op_i,
    input  logic [NUM_REQ-1:0][DWIDTH-1:0]  req_a_i,
    input  logic [NUM_REQ-1:0][DWIDTH-1:0]  req_b_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id_o,
    output logic [DWIDTH-1:0]               rsp_result_o
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]    r_rr_ptr;
    logic              r_rsp_valid;
    logic [IDW-1:0]    r_rsp_id;
    logic [DWIDTH-1:0] r_rsp_result;

    logic              w_can_accept;
    logic              w_xfer;
    logic [IDW-1:0]    w_grant;
    logic [DWIDTH-1:0] w_result;

    // First valid index at or after ptr, wrapping modulo NUM_REQ
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((32'(ptr) + i) % NUM_REQ);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Output register frees up when empty or being popped this cycle
    assign w_can_accept = !r_rsp_valid || rsp_ready_i;
    assign w_grant      = rr_pick(req_valid_i, r_rr_ptr);
    assign w_xfer       = !reset && w_can_accept && (|req_valid_i);

    always_comb begin
        req_ready_o = '0;
        if (w_xfer) begin
            req_ready_o[w_grant] = 1'b1;
        end
    end

    execute #(
        .DWIDTH (DWIDTH)
    ) u_execute (
        .i_op     (req_op_i[w_grant]),
        .i_a      (req_a_i[w_grant]),
        .i_b      (req_b_i[w_grant]),
        .i_shamt  (req_b_i[w_grant][4:0]),
        .o_result (w_result)
    );

    // Response register with same-cycle replace; pointer advances past the winner
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
        end else if (w_xfer) begin
            r_rr_ptr     <= IDW'((32'(w_grant) + 32'd1) % NUM_REQ);
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_grant;
            r_rsp_result <= w_result;
        end else if (rsp_ready_i) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_id_o     = r_rsp_id;
    assign rsp_result_o = r_rsp_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: directed self-checking bench for alu_arbiter (NUM_REQ=2, DWIDTH=32).
// Ports:   none (top-level bench).
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_op;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [0:0]       rsp_id;
    logic [31:0]      rsp_result;

    int n_cmp;
    int n_err;

    alu_arbiter #(
        .DWIDTH  (32),
        .NUM_REQ (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  sw_op  [4];
    logic [31:0] sw_a   [4];
    logic [31:0] sw_b   [4];
    logic [31:0] sw_exp [4];

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset held two cycles with both requesters valid
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_op[0] = ALU_ADD; req_a[0] = 32'd10; req_b[0] = 32'd1;
        req_op[1] = ALU_ADD; req_a[1] = 32'd20; req_b[1] = 32'd2;
        tick();
        check("rst_ready_c1", 32'(req_ready), 32'h0);
        tick();
        check("rst_ready_c2", 32'(req_ready), 32'h0);
        check("rst_valid",    32'(rsp_valid), 32'h0);
        check("rst_result",   rsp_result,     32'h0);
        check("rst_id",       32'(rsp_id),    32'h0);

        // Release: req0 wins first, then req1
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        check("first_valid",  32'(rsp_valid), 32'h1);
        check("first_id",     32'(rsp_id),    32'h0);
        check("first_result", rsp_result,     32'd11);
        check("second_ready", 32'(req_ready), 32'h2);
        tick();
        check("second_id",     32'(rsp_id), 32'h1);
        check("second_result", rsp_result,  32'd22);

        // Pop with no push empties the register, payload holds
        req_valid = 2'b00;
        #1;
        check("idle_ready", 32'(req_ready), 32'h0);
        tick();
        check("pop_valid",  32'(rsp_valid), 32'h0);
        check("pop_hold",   rsp_result,     32'd22);

        // Single request from req1: SUB 5-7
        req_valid = 2'b10;
        req_op[1] = ALU_SUB; req_a[1] = 32'd5; req_b[1] = 32'd7;
        #1;
        check("single_ready", 32'(req_ready), 32'h2);
        tick();
        check("single_valid",  32'(rsp_valid), 32'h1);
        check("single_id",     32'(rsp_id),    32'h1);
        check("single_result", rsp_result,     32'hFFFF_FFFE);

        // Fairness: both valid, result equals requester id, no bubbles
        req_valid = 2'b11;
        req_op[0] = ALU_ADD; req_a[0] = 32'd0; req_b[0] = 32'd0;
        req_op[1] = ALU_ADD; req_a[1] = 32'd1; req_b[1] = 32'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("fair_valid",  32'(rsp_valid), 32'h1);
            check("fair_id",     32'(rsp_id),    32'(i % 2));
            check("fair_result", rsp_result,     32'(i % 2));
        end

        // Backpressure: SRA result stalls, pending req1 waits
        req_valid = 2'b01;
        req_op[0] = ALU_SRA; req_a[0] = 32'h8000_0000; req_b[0] = 32'd4;
        #1;
        check("bp_ready0", 32'(req_ready), 32'h1);
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        req_op[1] = ALU_ADD; req_a[1] = 32'd3; req_b[1] = 32'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready_stall", 32'(req_ready), 32'h0);
            check("bp_result",      rsp_result,     32'hF800_0000);
            check("bp_id",          32'(rsp_id),    32'h0);
            check("bp_valid",       32'(rsp_valid), 32'h1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h2);
        tick();
        check("bp_replace_valid",  32'(rsp_valid), 32'h1);
        check("bp_replace_id",     32'(rsp_id),    32'h1);
        check("bp_replace_result", rsp_result,     32'd7);

        // Move the pointer to 1, then stall and reset mid-operation
        req_valid = 2'b01;
        req_op[0] = ALU_ADD; req_a[0] = 32'd100; req_b[0] = 32'd1;
        tick();
        check("pre_rst_result", rsp_result, 32'd101);
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        check("pre_rst_stall_ready", 32'(req_ready), 32'h0);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        check("mid_rst_valid",  32'(rsp_valid), 32'h0);
        check("mid_rst_result", rsp_result,     32'h0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_a[0]  = 32'd7; req_b[0] = 32'd8;
        #1;
        check("mid_rst_ptr_ready", 32'(req_ready), 32'h1);
        tick();
        check("mid_rst_after_id",     32'(rsp_id), 32'h0);
        check("mid_rst_after_result", rsp_result,  32'd15);

        // Op sweep through req1
        sw_op[0] = ALU_SLT;    sw_a[0] = 32'hFFFF_FFFF; sw_b[0] = 32'd1;          sw_exp[0] = 32'd1;
        sw_op[1] = ALU_SLTU;   sw_a[1] = 32'hFFFF_FFFF; sw_b[1] = 32'd1;          sw_exp[1] = 32'd0;
        sw_op[2] = ALU_PASS_B; sw_a[2] = 32'd0;         sw_b[2] = 32'h1234_5000;  sw_exp[2] = 32'h1234_5000;
        sw_op[3] = 4'hF;       sw_a[3] = 32'd2;         sw_b[3] = 32'd3;          sw_exp[3] = 32'd5;
        req_valid = 2'b10;
        for (int i = 0; i < 4; i++) begin
            req_op[1] = sw_op[i]; req_a[1] = sw_a[i]; req_b[1] = sw_b[i];
            #1;
            check("sweep_ready", 32'(req_ready), 32'h2);
            tick();
            check("sweep_id",     32'(rsp_id), 32'h1);
            check("sweep_result", rsp_result,  sw_exp[i]);
        end
        req_valid = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
